fetch_stage: RTL and testbench

- Instruction-fetch front end of the 3-stage RISC-V pipeline; the supplier side of the decode interface.
- Generates PCs, drives icache_addr/icache_re, and captures synchronous icache read data.
- Hands {inst, pc, valid} to the D stage under a valid/ready handshake.
- Absorbs decode back-pressure with a 1-entry skid buffer, flushes on X-stage redirect (branch/JAL/JALR), and freezes on global memory stall.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_skid_buffer.sv | 44 ++++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Constants shared by the fetch and decode stages: reset vector, the no-op
// used for bubbles, and the RV32I base opcodes.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} holding register that parks a fetched instruction
// while decode is back-pressuring.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture,
  input  logic        clear,
  input  logic        flush,
  input  logic [31:0] cap_inst,
  input  logic [31:0] cap_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  logic         valid_q;
  fetch_entry_t entry_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  // Payload carries no reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (capture) begin
      entry_q <= '{inst: cap_inst, pc: cap_pc};
    end
  end

  assign valid = valid_q;
  assign inst  = entry_q.inst;
  assign pc    = entry_q.pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, icache request/response
// capture, skid-buffered valid/ready hand-off to decode, redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic [31:0] icache_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc
);

  logic [31:0] pc_q;
  logic        req_valid_q;
  logic [31:0] req_pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_inst_q;
  logic [31:0] skid_pc_q;

  logic        advance;
  logic        redirect_go;
  logic [31:0] redirect_target;
  logic        issue;
  logic        transfer;
  logic        skid_capture;

  assign advance         = reset_n && !stall;
  assign redirect_go     = advance && redirect_valid;
  assign redirect_target = word_align(redirect_pc);

  // A new request may issue only if its response will have somewhere to land
  // next cycle: either the current holder drains now or nothing is held.
  assign issue = advance && (redirect_valid ||
                             (skid_valid_q ? d_ready : (!req_valid_q || d_ready)));

  assign icache_re   = issue;
  assign icache_addr = redirect_go ? redirect_target : pc_q;

  always_comb begin
    d_valid = 1'b0;
    d_inst  = NOP_INST;
    d_pc    = '0;
    if (reset_n && !redirect_go) begin
      if (skid_valid_q) begin
        d_valid = 1'b1;
        d_inst  = skid_inst_q;
        d_pc    = skid_pc_q;
      end else if (req_valid_q) begin
        d_valid = 1'b1;
        d_inst  = icache_dout;
        d_pc    = req_pc_q;
      end
    end
  end

  assign transfer     = d_valid && d_ready && !stall;
  assign skid_capture = advance && req_valid_q && !skid_valid_q && !d_ready && !redirect_valid;

  // ---- request stage: PC and in-flight tracking ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (!stall) begin
      if (redirect_valid) begin
        req_valid_q <= 1'b1;
        pc_q        <= redirect_target + 32'd4;
      end else if (issue) begin
        req_valid_q <= 1'b1;
        pc_q        <= pc_q + 32'd4;
      end else begin
        req_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc_q <= icache_addr;
    end
  end

  // ---- response stage: park the response when decode is not ready ----
  fetch_skid_buffer u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .capture  (skid_capture),
    .clear    (transfer),
    .flush    (redirect_go),
    .cap_inst (icache_dout),
    .cap_pc   (req_pc_q),
    .valid    (skid_valid_q),
    .inst     (skid_inst_q),
    .pc       (skid_pc_q)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver keeps a queue of the PCs decode
// should receive in program order; the monitor pops one per transfer.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_2000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        d_ready;
  logic [31:0] icache_dout = 32'h0;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] d_pc;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;

  logic [31:0] exp_q[$];
  logic [31:0] next_pc = RST_PC;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_ready        (d_ready),
    .d_valid        (d_valid),
    .d_inst         (d_inst),
    .d_pc           (d_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Synchronous icache: holds under stall, garbage when not read.
  always @(posedge clk) begin
    if (!stall) icache_dout <= icache_re ? mem_word(icache_addr) : $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic see(input logic v, input logic [31:0] pc);
    check_bit("dir_valid", d_valid, v);
    if (v) check("dir_pc", d_pc, pc);
  endtask

  // Drive one cycle and update the expected program-order stream.
  task automatic cyc(input logic rn, input logic st, input logic rv,
                     input logic [31:0] rpc, input logic dr);
    @(posedge clk);
    #1;
    reset_n        = rn;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    d_ready        = dr;
    if (!rn) begin
      exp_q.delete();
      next_pc = RST_PC;
    end else if (rv && !st) begin
      exp_q.delete();
      next_pc = {rpc[31:2], 2'b00};
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
    #1;
  endtask

  logic        prev_rn = 1'b0, prev_stall = 1'b0, prev_issue = 1'b0, prev_hold = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = '0, prev_inst = '0, prev_pc = '0;
  logic        squash;
  logic [31:0] e_pc;

  always @(negedge clk) begin
    squash = redirect_valid && !stall;
    if (reset_n !== 1'b1) begin
      check_bit("rst_d_valid", d_valid, 1'b0);
      check_bit("rst_re", icache_re, 1'b0);
      check("rst_d_inst", d_inst, NOP);
      check("rst_d_pc", d_pc, 32'h0);
    end else begin
      if (prev_issue && !squash) check_bit("latency_valid", d_valid, 1'b1);
      if (prev_hold && !squash) begin
        check("hold_pc", d_pc, prev_pc);
        check("hold_inst", d_inst, prev_inst);
      end
      if (stall) begin
        check_bit("stall_re", icache_re, 1'b0);
        if (prev_stall && prev_rn) begin
          check("stall_addr", icache_addr, prev_addr);
          check_bit("stall_valid", d_valid, prev_valid);
          check("stall_pc", d_pc, prev_pc);
          check("stall_inst", d_inst, prev_inst);
        end
      end
      if (squash) begin
        check_bit("redir_valid", d_valid, 1'b0);
        check_bit("redir_re", icache_re, 1'b1);
        check("redir_addr", icache_addr, {redirect_pc[31:2], 2'b00});
      end
      if (d_valid && !d_ready && !stall) check_bit("hold_no_re", icache_re, 1'b0);
      if (!d_valid) begin
        check("idle_inst", d_inst, NOP);
        check("idle_pc", d_pc, 32'h0);
      end
      if (d_valid && d_ready && !stall) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL xfer_underflow: got pc %h expected none at %0t", d_pc, $time);
        end else begin
          e_pc = exp_q.pop_front();
          check("xfer_pc", d_pc, e_pc);
          check("xfer_inst", d_inst, mem_word(e_pc));
        end
      end
    end
    prev_rn    = (reset_n === 1'b1);
    prev_stall = stall;
    prev_issue = (reset_n === 1'b1) && icache_re;
    prev_hold  = (reset_n === 1'b1) && d_valid && !(d_ready && !stall);
    prev_valid = d_valid;
    prev_addr  = icache_addr;
    prev_inst  = d_inst;
    prev_pc    = d_pc;
  end

  logic [31:0] rec_pc;

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // sequential stream straight out of reset
    cyc(1, 0, 0, 0, 1);
    check("first_addr", icache_addr, RST_PC);
    check_bit("first_re", icache_re, 1'b1);
    cyc(1, 0, 0, 0, 1); see(1, 32'h2000);

    // decode holds for three cycles
    cyc(1, 0, 0, 0, 0); see(1, 32'h2004);
    cyc(1, 0, 0, 0, 0); see(1, 32'h2004);
    cyc(1, 0, 0, 0, 0); see(1, 32'h2004);
    cyc(1, 0, 0, 0, 1); see(1, 32'h2004);
    cyc(1, 0, 0, 0, 1); see(1, 32'h2008);
    cyc(1, 0, 0, 0, 1); see(1, 32'h200C);

    // redirect with the skid entry occupied
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h3000, 0);
    see(0, 32'h0);
    check("redir3000_addr", icache_addr, 32'h3000);
    cyc(1, 0, 0, 0, 1); see(1, 32'h3000);

    // unaligned redirect target
    cyc(1, 0, 1, 32'h3002, 1);
    check("unaligned_addr", icache_addr, 32'h3000);
    cyc(1, 0, 0, 0, 1); see(1, 32'h3000);

    // stall with a redirect pulse that must be ignored
    cyc(1, 1, 0, 0, 1);
    rec_pc = d_pc;
    cyc(1, 1, 1, 32'h5000, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); see(1, rec_pc);
    cyc(1, 0, 0, 0, 1); see(1, rec_pc + 32'd4);

    // reset with a buffered instruction
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    see(0, 32'h0);
    check_bit("midrst_re", icache_re, 1'b0);
    cyc(1, 0, 0, 0, 1);
    check("rerst_addr", icache_addr, RST_PC);
    cyc(1, 0, 0, 0, 1); see(1, RST_PC);

    // wrap past the top of the address space
    cyc(1, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 0, 1);
    see(1, 32'hFFFF_FFFC);
    check("wrap_addr", icache_addr, 32'h0);
    check_bit("wrap_re", icache_re, 1'b1);
    cyc(1, 0, 0, 0, 1); see(1, 32'h0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic        rn, st, rv, dr;
      logic [31:0] rpc;
      rn  = ($urandom_range(99) != 0);
      st  = ($urandom_range(9) == 0);
      rv  = ($urandom_range(19) == 0);
      dr  = ($urandom_range(9) < 7);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      cyc(rn, st, rv, rpc, dr);
    end

    cyc(1, 0, 0, 0, 1);
    check_bit("xfer_progress", n_xfer > 1000, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
